// File: rtl/writeback_unit_pkg.sv
// rtl/writeback_unit_pkg.sv - shared encodings for the writeback stage
package writeback_unit_pkg;

    // Retiring instruction kinds
    typedef enum logic [1:0] {
        KIND_NONE = 2'd0,
        KIND_ALU  = 2'd1,
        KIND_LOAD = 2'd2,
        KIND_LINK = 2'd3
    } kind_e;

    // Load access sizes; encoding 3 is unused and treated like a word
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    // Register written by LINK instructions
    localparam int LINK_REG = 31;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_LOAD = 2'd1,
        S_WRITE     = 2'd2
    } state_e;

    // Half needs addr_lo[0]==0, word needs addr_lo==0, byte is always aligned
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return addr_lo[0];
            default:   return addr_lo != 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/writeback_unit_load_align.sv
// rtl/writeback_unit_load_align.sv - load data lane select and extension
// Ports: rdata (little-endian word), size, sign_ext, addr_lo in;
//        data (aligned, extended), misalign out. Purely combinational.
module load_align
    import writeback_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rdata,
    input  logic [1:0]       size,
    input  logic             sign_ext,
    input  logic [1:0]       addr_lo,
    output logic [WIDTH-1:0] data,
    output logic             misalign
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b   = rdata[{addr_lo, 3'b000} +: 8];
        lane_h   = rdata[{addr_lo[1], 4'b0000} +: 16];
        misalign = is_misaligned(size, addr_lo);
        case (size)
            SIZE_BYTE: data = {{(WIDTH-8){sign_ext & lane_b[7]}}, lane_b};
            SIZE_HALF: data = {{(WIDTH-16){sign_ext & lane_h[15]}}, lane_h};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - final pipeline stage driving the register file write port
// Ports: clk, reset (async, active-low); ex_* retiring instruction handshake;
//        mem_rvalid/mem_rdata load response; regWriteEn/Rdest/writeData to the
//        register file; fwd_* bypass copy of the write; load_err sticky error.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int REGBITS      = 5,
    parameter int LOAD_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ex_valid,
    output logic               ex_ready,
    input  logic [1:0]         ex_kind,
    input  logic [REGBITS-1:0] ex_rdest,
    input  logic [WIDTH-1:0]   ex_result,
    input  logic [1:0]         ex_size,
    input  logic               ex_signed,
    input  logic [1:0]         ex_addr_lo,
    input  logic               mem_rvalid,
    input  logic [WIDTH-1:0]   mem_rdata,
    output logic               regWriteEn,
    output logic [REGBITS-1:0] Rdest,
    output logic [WIDTH-1:0]   writeData,
    output logic               fwd_valid,
    output logic [REGBITS-1:0] fwd_rdest,
    output logic [WIDTH-1:0]   fwd_data,
    output logic               load_err
);

    state_e             state;
    logic [7:0]         cnt;
    logic [REGBITS-1:0] ld_dest;
    logic [1:0]         ld_size;
    logic               ld_signed;
    logic [1:0]         ld_addr_lo;

    // One aligner serves both jobs: outside WAIT_LOAD it checks the incoming
    // instruction for misalignment, inside WAIT_LOAD it shapes the response.
    logic               waiting;
    logic [1:0]         al_size;
    logic               al_signed;
    logic [1:0]         al_addr_lo;
    logic [WIDTH-1:0]   al_data;
    logic               al_misalign;

    assign waiting    = (state == S_WAIT_LOAD);
    assign al_size    = waiting ? ld_size    : ex_size;
    assign al_signed  = waiting ? ld_signed  : ex_signed;
    assign al_addr_lo = waiting ? ld_addr_lo : ex_addr_lo;

    load_align #(.WIDTH(WIDTH)) u_align (
        .rdata    (mem_rdata),
        .size     (al_size),
        .sign_ext (al_signed),
        .addr_lo  (al_addr_lo),
        .data     (al_data),
        .misalign (al_misalign)
    );

    // Outcome of accepting the presented instruction (only used in IDLE/WRITE)
    state_e             acc_state;
    logic               acc_we;
    logic [REGBITS-1:0] acc_dest;
    logic               acc_err;

    always_comb begin
        acc_state = S_IDLE;
        acc_we    = 1'b0;
        acc_dest  = ex_rdest;
        acc_err   = 1'b0;
        if (ex_valid) begin
            case (ex_kind)
                KIND_ALU: begin
                    acc_state = S_WRITE;
                    acc_we    = (ex_rdest != '0);
                end
                KIND_LINK: begin
                    acc_state = S_WRITE;
                    acc_dest  = REGBITS'(LINK_REG);
                    acc_we    = 1'b1;
                end
                KIND_LOAD: begin
                    if (al_misalign) acc_err = 1'b1;
                    else             acc_state = S_WAIT_LOAD;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            ex_ready   <= 1'b1;
            regWriteEn <= 1'b0;
            Rdest      <= '0;
            writeData  <= '0;
            load_err   <= 1'b0;
            cnt        <= '0;
            ld_dest    <= '0;
            ld_size    <= '0;
            ld_signed  <= 1'b0;
            ld_addr_lo <= '0;
        end else begin
            regWriteEn <= 1'b0;
            if (state == S_WAIT_LOAD) begin
                if (mem_rvalid) begin
                    state      <= S_WRITE;
                    ex_ready   <= 1'b1;
                    regWriteEn <= (ld_dest != '0);
                    Rdest      <= ld_dest;
                    writeData  <= al_data;
                end else if (cnt == 8'(LOAD_TIMEOUT - 1)) begin
                    // This edge is the LOAD_TIMEOUT-th cycle spent waiting
                    state    <= S_IDLE;
                    ex_ready <= 1'b1;
                    load_err <= 1'b1;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end else begin
                state    <= acc_state;
                ex_ready <= (acc_state != S_WAIT_LOAD);
                if (acc_err) load_err <= 1'b1;
                if (acc_state == S_WRITE) begin
                    regWriteEn <= acc_we;
                    Rdest      <= acc_dest;
                    writeData  <= ex_result;
                end
                if (acc_state == S_WAIT_LOAD) begin
                    cnt        <= '0;
                    ld_dest    <= ex_rdest;
                    ld_size    <= ex_size;
                    ld_signed  <= ex_signed;
                    ld_addr_lo <= ex_addr_lo;
                end
            end
        end
    end

    assign fwd_valid = regWriteEn;
    assign fwd_rdest = Rdest;
    assign fwd_data  = writeData;

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - directed self-checking bench for writeback_unit
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic [1:0]  ex_kind;
    logic [4:0]  ex_rdest;
    logic [31:0] ex_result;
    logic [1:0]  ex_size;
    logic        ex_signed;
    logic [1:0]  ex_addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        regWriteEn;
    logic [4:0]  Rdest;
    logic [31:0] writeData;
    logic        fwd_valid;
    logic [4:0]  fwd_rdest;
    logic [31:0] fwd_data;
    logic        load_err;

    int n_checks = 0;
    int n_fail   = 0;

    writeback_unit #(.WIDTH(32), .REGBITS(5), .LOAD_TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_kind    (ex_kind),
        .ex_rdest   (ex_rdest),
        .ex_result  (ex_result),
        .ex_size    (ex_size),
        .ex_signed  (ex_signed),
        .ex_addr_lo (ex_addr_lo),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .regWriteEn (regWriteEn),
        .Rdest      (Rdest),
        .writeData  (writeData),
        .fwd_valid  (fwd_valid),
        .fwd_rdest  (fwd_rdest),
        .fwd_data   (fwd_data),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_write(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] wd);
        chk({tag, ".we"},   32'(regWriteEn), 32'(we));
        chk({tag, ".fwdv"}, 32'(fwd_valid),  32'(we));
        if (we) begin
            chk({tag, ".rd"},   32'(Rdest),     32'(rd));
            chk({tag, ".wd"},   writeData,      wd);
            chk({tag, ".fwdr"}, 32'(fwd_rdest), 32'(rd));
            chk({tag, ".fwdd"}, fwd_data,       wd);
        end
    endtask

    task automatic present(input logic [1:0] kind, input logic [4:0] rd, input logic [31:0] res,
                           input logic [1:0] sz, input logic sg, input logic [1:0] lo);
        ex_valid   = 1'b1;
        ex_kind    = kind;
        ex_rdest   = rd;
        ex_result  = res;
        ex_size    = sz;
        ex_signed  = sg;
        ex_addr_lo = lo;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        reset      = 1'b0;
        ex_valid   = 1'b0;
        ex_kind    = 2'd0;
        ex_rdest   = 5'd0;
        ex_result  = 32'd0;
        ex_size    = 2'd0;
        ex_signed  = 1'b0;
        ex_addr_lo = 2'd0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        step();
        step();

        // Reset values
        chk("rst.ready", 32'(ex_ready),   32'd1);
        chk("rst.we",    32'(regWriteEn), 32'd0);
        chk("rst.rd",    32'(Rdest),      32'd0);
        chk("rst.wd",    writeData,       32'd0);
        chk("rst.fwdd",  fwd_data,        32'd0);
        chk("rst.err",   32'(load_err),   32'd0);
        reset = 1'b1;
        step();

        // ALU write
        present(2'd1, 5'd5, 32'hDEADBEEF, 2'd2, 1'b0, 2'd0);
        step();
        chk_write("alu", 1'b1, 5'd5, 32'hDEADBEEF);
        chk("alu.ready", 32'(ex_ready), 32'd1);

        // LINK goes to r31 regardless of rdest
        present(2'd3, 5'd7, 32'h00400010, 2'd2, 1'b0, 2'd0);
        step();
        chk_write("link", 1'b1, 5'd31, 32'h00400010);

        // ALU to r0 never writes
        present(2'd1, 5'd0, 32'h12345678, 2'd2, 1'b0, 2'd0);
        step();
        chk_write("alu_r0", 1'b0, 5'd0, 32'd0);
        ex_valid = 1'b0;
        step();
        chk_write("idle", 1'b0, 5'd0, 32'd0);

        // Signed byte load, addr_lo=3, response two cycles after accept
        present(2'd2, 5'd9, 32'd0, 2'd0, 1'b1, 2'd3);
        step();
        ex_valid = 1'b0;
        chk("sb.ready0", 32'(ex_ready), 32'd0);
        chk_write("sb.wait0", 1'b0, 5'd0, 32'd0);
        step();
        chk("sb.ready1", 32'(ex_ready), 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h80112233;
        step();
        mem_rvalid = 1'b0;
        chk_write("sb", 1'b1, 5'd9, 32'hFFFFFF80);
        chk("sb.ready2", 32'(ex_ready), 32'd1);

        // Same load unsigned
        present(2'd2, 5'd10, 32'd0, 2'd0, 1'b0, 2'd3);
        step();
        ex_valid = 1'b0;
        step();
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        chk_write("ub", 1'b1, 5'd10, 32'h00000080);

        // Signed half, upper lane: 0x8011 -> 0xFFFF8011
        present(2'd2, 5'd11, 32'd0, 2'd1, 1'b1, 2'd2);
        step();
        ex_valid   = 1'b0;
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        chk_write("sh", 1'b1, 5'd11, 32'hFFFF8011);

        // Word load passes through
        present(2'd2, 5'd12, 32'd0, 2'd2, 1'b1, 2'd0);
        step();
        ex_valid   = 1'b0;
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        chk_write("lw", 1'b1, 5'd12, 32'h80112233);
        chk("lw.err", 32'(load_err), 32'd0);

        // Misaligned half
        present(2'd2, 5'd13, 32'd0, 2'd1, 1'b0, 2'd1);
        step();
        ex_valid = 1'b0;
        chk("mis.err",   32'(load_err), 32'd1);
        chk("mis.ready", 32'(ex_ready), 32'd1);
        chk_write("mis", 1'b0, 5'd0, 32'd0);
        step();
        chk("mis.sticky", 32'(load_err), 32'd1);

        do_reset();
        chk("rst2.err", 32'(load_err), 32'd0);

        // Timeout after 4 cycles in WAIT_LOAD
        present(2'd2, 5'd14, 32'd0, 2'd2, 1'b0, 2'd0);
        step();
        ex_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk($sformatf("to.err%0d", i),   32'(load_err), 32'd0);
            chk($sformatf("to.ready%0d", i), 32'(ex_ready), 32'd0);
        end
        step();
        chk("to.err4",   32'(load_err), 32'd1);
        chk("to.ready4", 32'(ex_ready), 32'd1);
        chk_write("to", 1'b0, 5'd0, 32'd0);
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        chk_write("to.stray", 1'b0, 5'd0, 32'd0);

        do_reset();

        // Five back-to-back ALU ops
        for (int i = 0; i < 5; i++) begin
            present(2'd1, 5'(i + 1), 32'h1000 + 32'(i), 2'd2, 1'b0, 2'd0);
            step();
            chk_write($sformatf("b2b%0d", i), 1'b1, 5'(i + 1), 32'h1000 + 32'(i));
        end
        ex_valid = 1'b0;
        step();
        chk_write("b2b.end", 1'b0, 5'd0, 32'd0);

        // Reset while waiting on a load
        present(2'd2, 5'd15, 32'd0, 2'd2, 1'b0, 2'd0);
        step();
        ex_valid = 1'b0;
        chk("rwl.ready0", 32'(ex_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("rwl.ready", 32'(ex_ready),   32'd1);
        chk("rwl.we",    32'(regWriteEn), 32'd0);
        chk("rwl.rd",    32'(Rdest),      32'd0);
        chk("rwl.wd",    writeData,       32'd0);
        step();
        reset      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFEF00D;
        step();
        mem_rvalid = 1'b0;
        chk_write("rwl.late", 1'b0, 5'd0, 32'd0);
        chk("rwl.ready2", 32'(ex_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
